sched_cmd_ctrl: RTL

//  Host/CPU-facing command front-end for the mixed-criticality EDF scheduler core.
//  - Host side: stages task descriptors from 32-bit register writes, commits them to the scheduler task table,
//    and holds the global controls (enable, transition_nums).
//  - Wakeup side: arbitrates wakeups from external IRQ lines and software onto the scheduler's single

---
 rtl/sched_cmd_ctrl_pkg.sv | 59 +++++
 rtl/sched_cmd_ctrl_if.sv | 45 ++++
 rtl/sched_cmd_ctrl_rr_pick.sv | 27 ++
 rtl/sched_cmd_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sched_cmd_ctrl_pkg.sv
// Shared types and constants for the scheduler command front-end.
// Holds the task-table descriptor layout, the host register indices
// and the field positions used inside host write data.
package sched_cmd_ctrl_pkg;

  localparam int MAX_TASKS   = 32;
  localparam int TB          = $clog2(MAX_TASKS);
  localparam int TIME_BITS   = 32;
  localparam int NUM_IRQ     = 8;
  localparam int IRQ_W       = $clog2(NUM_IRQ);
  localparam int ADDR_W      = 4;
  localparam int NUM_TNUMS   = 4;
  localparam int TNUM_STRIDE = 5;

  // Host register indices
  localparam logic [ADDR_W-1:0] REG_PERIOD    = 4'd0;
  localparam logic [ADDR_W-1:0] REG_VDEADLINE = 4'd1;
  localparam logic [ADDR_W-1:0] REG_EX_HIGH   = 4'd2;
  localparam logic [ADDR_W-1:0] REG_EX_LOW    = 4'd3;
  localparam logic [ADDR_W-1:0] REG_COMMIT    = 4'd4;
  localparam logic [ADDR_W-1:0] REG_SWWAKE    = 4'd5;
  localparam logic [ADDR_W-1:0] REG_IRQMAP    = 4'd6;
  localparam logic [ADDR_W-1:0] REG_GLOBAL    = 4'd7;
  localparam logic [ADDR_W-1:0] REG_TNUMS     = 4'd8;

  // Bit positions inside COMMIT / IRQMAP write data
  localparam int COMMIT_TYPE_BIT = 8;
  localparam int COMMIT_CRIT_BIT = 9;
  localparam int IRQMAP_ID_LSB   = 8;
  localparam int IRQMAP_EN_BIT   = 16;

  typedef enum logic {
    TASK_PERIODIC = 1'b0,
    TASK_SPORADIC = 1'b1
  } TASK_TYPE;

  typedef enum logic {
    CRIT_LOW  = 1'b0,
    CRIT_HIGH = 1'b1
  } TASK_CRIT_IN;

  typedef struct packed {
    logic                 valid;
    logic [TB-1:0]        id;
    TASK_TYPE             task_type;
    TASK_CRIT_IN          crit;
    logic [TIME_BITS-1:0] period;
    logic [TIME_BITS-1:0] virtual_deadline;
    logic [TIME_BITS-1:0] ex_high;
    logic [TIME_BITS-1:0] ex_low;
  } TASK_TABLE_INPUT;

  // One entry of the external IRQ -> task id routing table
  typedef struct packed {
    logic          enable;
    logic [TB-1:0] id;
  } irq_map_t;

endpackage

// File: rtl/sched_cmd_ctrl_if.sv
// Bundle of host, wakeup, CPU and scheduler-facing signals of the command
// front-end. master = host/CPU/scheduler environment, slave = front-end.
interface sched_cmd_ctrl_if;
  import sched_cmd_ctrl_pkg::*;

  logic                           host_wr_valid;
  logic                           host_wr_ready;
  logic [ADDR_W-1:0]              host_wr_addr;
  logic [31:0]                    host_wr_data;
  logic [NUM_IRQ-1:0]             irq_in;
  logic                           cpu_done_valid;
  logic                           cpu_done_ok;
  logic                           cpu_done_ready;
  logic                           sched_running_valid;
  logic                           sched_cpu_int;
  logic                           cpu_irq;
  logic                           cpu_irq_ack;
  TASK_TABLE_INPUT                input_task;
  logic                           wakeup_valid;
  logic [TB-1:0]                  wakeup_id;
  logic                           completion_valid;
  logic                           completion_succesful;
  logic [NUM_TNUMS-1:0][TB-1:0]   transition_nums;
  logic                           sched_en;
  logic                           err_cpl_drop;

  modport master (
    output host_wr_valid, host_wr_addr, host_wr_data, irq_in,
           cpu_done_valid, cpu_done_ok, sched_running_valid,
           sched_cpu_int, cpu_irq_ack,
    input  host_wr_ready, cpu_done_ready, cpu_irq, input_task,
           wakeup_valid, wakeup_id, completion_valid,
           completion_succesful, transition_nums, sched_en, err_cpl_drop
  );

  modport slave (
    input  host_wr_valid, host_wr_addr, host_wr_data, irq_in,
           cpu_done_valid, cpu_done_ok, sched_running_valid,
           sched_cpu_int, cpu_irq_ack,
    output host_wr_ready, cpu_done_ready, cpu_irq, input_task,
           wakeup_valid, wakeup_id, completion_valid,
           completion_succesful, transition_nums, sched_en, err_cpl_drop
  );

endinterface

// File: rtl/sched_cmd_ctrl_rr_pick.sv
// Round-robin first-set-bit picker: finds the first set bit of bitmap
// searching upward from ptr+1 and wrapping. ptr itself is the last slot
// checked. Wrap relies on MAX_TASKS being a power of two.
module sched_rr_pick
  import sched_cmd_ctrl_pkg::*;
(
  input  logic [MAX_TASKS-1:0] bitmap,
  input  logic [TB-1:0]        ptr,
  output logic                 found,
  output logic [TB-1:0]        idx
);

  logic [TB-1:0] cand_s;

  // Scan from the farthest slot to the nearest so the closest hit after ptr is kept
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    cand_s = '0;
    for (int i = MAX_TASKS; i >= 1; i--) begin
      cand_s = ptr + TB'(i);
      found  = found | bitmap[cand_s];
      idx    = bitmap[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/sched_cmd_ctrl.sv
// Host/CPU command front-end of the mixed-criticality EDF scheduler:
// host register file with task-descriptor staging and commit, IRQ/software
// wakeup arbitration onto a single wakeup port, completion forwarding and
// the sticky preemption interrupt towards the CPU.
module sched_cmd_ctrl
  import sched_cmd_ctrl_pkg::*;
(
  input logic             clk,
  input logic             rst,
  sched_cmd_ctrl_if.slave bus
);

  // Host register state
  logic [TIME_BITS-1:0]         period_r;
  logic [TIME_BITS-1:0]         vdeadline_r;
  logic [TIME_BITS-1:0]         ex_high_r;
  logic [TIME_BITS-1:0]         ex_low_r;
  TASK_TABLE_INPUT              input_task_r;
  logic                         commit_gap_r;
  irq_map_t                     irq_map_r [NUM_IRQ];
  logic                         sched_en_r;
  logic [NUM_TNUMS-1:0][TB-1:0] tnums_r;

  // Wakeup state
  logic [NUM_IRQ-1:0]   irq_prev_r;
  logic [MAX_TASKS-1:0] pending_r;
  logic [TB-1:0]        rr_ptr_r;
  logic                 wakeup_valid_r;
  logic [TB-1:0]        wakeup_id_r;

  // Completion / interrupt state
  logic completion_valid_r;
  logic completion_ok_r;
  logic err_cpl_drop_r;
  logic cpu_irq_r;

  // Combinational helpers
  logic                 wr_acc_s;
  logic                 commit_acc_s;
  logic                 swwake_acc_s;
  logic                 cpl_acc_s;
  logic [NUM_IRQ-1:0]   irq_rise_s;
  logic [MAX_TASKS-1:0] set_s;
  logic [MAX_TASKS-1:0] commit_mask_s;
  logic [MAX_TASKS-1:0] pick_map_s;
  logic [MAX_TASKS-1:0] grant_clr_s;
  logic [MAX_TASKS-1:0] pending_nxt_s;
  logic                 pick_found_s;
  logic [TB-1:0]        pick_idx_s;

  // Ready is held low in reset and for one cycle after each commit
  assign bus.host_wr_ready  = ~rst & ~commit_gap_r;
  assign bus.cpu_done_ready = ~rst;

  assign wr_acc_s     = bus.host_wr_valid & bus.host_wr_ready;
  assign commit_acc_s = wr_acc_s & (bus.host_wr_addr == REG_COMMIT);
  assign swwake_acc_s = wr_acc_s & (bus.host_wr_addr == REG_SWWAKE);
  assign cpl_acc_s    = bus.cpu_done_valid & bus.cpu_done_ready;

  // Host register file: staging, IRQ routing, globals and the one-cycle commit pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      period_r     <= '0;
      vdeadline_r  <= '0;
      ex_high_r    <= '0;
      ex_low_r     <= '0;
      input_task_r <= '0;
      commit_gap_r <= 1'b0;
      sched_en_r   <= 1'b0;
      tnums_r      <= '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
        irq_map_r[k] <= '0;
      end
    end else begin
      commit_gap_r       <= commit_acc_s;
      input_task_r.valid <= 1'b0;
      if (wr_acc_s) begin
        case (bus.host_wr_addr)
          REG_PERIOD:    period_r    <= bus.host_wr_data[TIME_BITS-1:0];
          REG_VDEADLINE: vdeadline_r <= bus.host_wr_data[TIME_BITS-1:0];
          REG_EX_HIGH:   ex_high_r   <= bus.host_wr_data[TIME_BITS-1:0];
          REG_EX_LOW:    ex_low_r    <= bus.host_wr_data[TIME_BITS-1:0];
          REG_COMMIT: begin
            input_task_r <= '{valid:            1'b1,
                              id:               bus.host_wr_data[TB-1:0],
                              task_type:        TASK_TYPE'(bus.host_wr_data[COMMIT_TYPE_BIT]),
                              crit:             TASK_CRIT_IN'(bus.host_wr_data[COMMIT_CRIT_BIT]),
                              period:           period_r,
                              virtual_deadline: vdeadline_r,
                              ex_high:          ex_high_r,
                              ex_low:           ex_low_r};
          end
          REG_IRQMAP: begin
            irq_map_r[bus.host_wr_data[IRQ_W-1:0]] <= '{enable: bus.host_wr_data[IRQMAP_EN_BIT],
                                                        id:     bus.host_wr_data[IRQMAP_ID_LSB +: TB]};
          end
          REG_GLOBAL: sched_en_r <= bus.host_wr_data[0];
          REG_TNUMS: begin
            for (int i = 0; i < NUM_TNUMS; i++) begin
              tnums_r[i] <= bus.host_wr_data[i*TNUM_STRIDE +: TB];
            end
          end
          // SWWAKE is consumed by the pending bitmap; other indices are ignored
          default: ;
        endcase
      end
    end
  end

  // Collect wakeup requests, mask the id being committed, and form the next pending set
  always_comb begin
    irq_rise_s    = bus.irq_in & ~irq_prev_r;
    set_s         = '0;
    commit_mask_s = '0;
    grant_clr_s   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      set_s[irq_map_r[k].id] = set_s[irq_map_r[k].id] | (irq_rise_s[k] & irq_map_r[k].enable);
    end
    set_s[bus.host_wr_data[TB-1:0]] = set_s[bus.host_wr_data[TB-1:0]] | swwake_acc_s;
    commit_mask_s[input_task_r.id]  = input_task_r.valid;
    pick_map_s                      = pending_r & ~commit_mask_s;
    grant_clr_s[pick_idx_s]         = pick_found_s;
    // A new request for the granted id survives the clear
    pending_nxt_s = (pending_r & ~grant_clr_s) | set_s;
  end

  sched_rr_pick u_pick (
    .bitmap (pick_map_s),
    .ptr    (rr_ptr_r),
    .found  (pick_found_s),
    .idx    (pick_idx_s)
  );

  // Pending bitmap, IRQ edge history and the registered wakeup grant
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_r     <= '0;
      pending_r      <= '0;
      rr_ptr_r       <= TB'(MAX_TASKS - 1);
      wakeup_valid_r <= 1'b0;
      wakeup_id_r    <= '0;
    end else begin
      irq_prev_r     <= bus.irq_in;
      pending_r      <= pending_nxt_s;
      wakeup_valid_r <= pick_found_s;
      if (pick_found_s) begin
        wakeup_id_r <= pick_idx_s;
        rr_ptr_r    <= pick_idx_s;
      end
    end
  end

  // Completion pulse towards the scheduler and the sticky drop error
  always_ff @(posedge clk) begin
    if (rst) begin
      completion_valid_r <= 1'b0;
      completion_ok_r    <= 1'b0;
      err_cpl_drop_r     <= 1'b0;
    end else begin
      completion_valid_r <= cpl_acc_s & bus.sched_running_valid;
      completion_ok_r    <= cpl_acc_s & bus.sched_running_valid & bus.cpu_done_ok;
      if (cpl_acc_s && !bus.sched_running_valid) begin
        err_cpl_drop_r <= 1'b1;
      end
    end
  end

  // Preemption interrupt: set by the scheduler pulse, cleared by ack, set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_irq_r <= 1'b0;
    end else begin
      cpu_irq_r <= bus.sched_cpu_int | (cpu_irq_r & ~bus.cpu_irq_ack);
    end
  end

  assign bus.input_task           = input_task_r;
  assign bus.wakeup_valid         = wakeup_valid_r;
  assign bus.wakeup_id            = wakeup_id_r;
  assign bus.completion_valid     = completion_valid_r;
  assign bus.completion_succesful = completion_ok_r;
  assign bus.transition_nums      = tnums_r;
  assign bus.sched_en             = sched_en_r;
  assign bus.err_cpl_drop         = err_cpl_drop_r;
  assign bus.cpu_irq              = cpu_irq_r;

endmodule
